// File: rtl/load_pkg.sv
// Shared types for the in-order load queue: funct3 encodings, exception causes
// and the FIFO entry layout.
package load_pkg;

  localparam int EA_W = 64;

  typedef enum logic [2:0] {
    W_LB  = 3'b000,
    W_LH  = 3'b001,
    W_LW  = 3'b010,
    W_LD  = 3'b011,
    W_LBU = 3'b100,
    W_LHU = 3'b101,
    W_LWU = 3'b110,
    W_ILL = 3'b111
  } width_e;

  localparam logic [3:0] CAUSE_ILLEGAL  = 4'd2;
  localparam logic [3:0] CAUSE_MISALIGN = 4'd4;
  localparam logic [3:0] CAUSE_ACCESS   = 4'd5;

  typedef struct packed {
    logic [4:0]      dest;
    width_e          width;
    logic [EA_W-1:0] ea;
    logic            skip;
    logic [3:0]      cause;
  } lq_entry_t;

  // LD and LWU only exist on RV64.
  function automatic logic width_illegal(input logic [2:0] w, input int xlen);
    return (w == W_ILL) || ((xlen == 32) && ((w == W_LD) || (w == W_LWU)));
  endfunction

endpackage

// File: rtl/load_extract.sv
// Read-data lane extraction: shift the beat down to the addressed byte, then
// sign- or zero-extend the selected 8/16/32/64 bits to XLEN.
module load_extract
  import load_pkg::*;
#(
  parameter int XLEN = 64,
  parameter int DLEN = 64,
  parameter int OFFW = 3
) (
  input  logic [DLEN-1:0] rdata,
  input  logic [OFFW-1:0] offset,
  input  logic [2:0]      width,
  output logic [XLEN-1:0] data
);

  logic [DLEN-1:0] sh;
  logic [XLEN-1:0] raw;
  logic [XLEN-1:0] mask;
  logic            msb;

  always_comb begin
    sh  = rdata >> {offset, 3'b000};
    raw = sh[XLEN-1:0];
    case (width[1:0])
      2'd0:    begin mask = XLEN'(8'hFF);         msb = raw[7];      end
      2'd1:    begin mask = XLEN'(16'hFFFF);      msb = raw[15];     end
      2'd2:    begin mask = XLEN'(32'hFFFF_FFFF); msb = raw[31];     end
      default: begin mask = '1;                   msb = raw[XLEN-1]; end
    endcase
    // funct3[2] clear selects the signed variants
    data = (raw & mask) | ((!width[2] && msb) ? ~mask : '0);
  end

endmodule

// File: rtl/load_queue_unit.sv
// In-order multi-outstanding load unit on an AXI4-Lite read master.
// LOAD_MISALIGN_EXC_EN: trap naturally-misaligned loads (cause 4) instead of issuing them.
module load_queue_unit
  import load_pkg::*;
#(
  parameter int XLEN  = 64,
  parameter int ALEN  = XLEN,
  parameter int DLEN  = XLEN,
  parameter int SLEN  = DLEN / 8,
  parameter int DEPTH = 4
) (
  input  logic            clk,
  input  logic            rstn,
  input  logic            i_tvalid,
  output logic            o_tready,
  input  logic [XLEN-1:0] i_base_addr,
  input  logic [XLEN-1:0] i_offset,
  input  logic [2:0]      i_width,
  input  logic [4:0]      i_dest,
  output logic [ALEN-1:0] o_araddr,
  output logic [2:0]      o_arprot,
  output logic            o_arvalid,
  input  logic            i_arready,
  input  logic [DLEN-1:0] i_rdata,
  input  logic [1:0]      i_rresp,
  input  logic            i_rvalid,
  output logic            o_rready,
  output logic            o_rf_wvalid,
  input  logic            i_rf_wready,
  output logic [4:0]      o_rf_waddr,
  output logic [XLEN-1:0] o_rf_wdata,
  output logic            o_exc_valid,
  output logic [3:0]      o_exc_cause,
  output logic [XLEN-1:0] o_exc_tval,
  output logic            o_busy
);

  localparam int OFFW = $clog2(SLEN);
  localparam int PW   = $clog2(DEPTH);
  localparam int CW   = PW + 1;

  lq_entry_t       fifo_q [DEPTH];
  lq_entry_t       fifo_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            arvalid_q, arvalid_d;
  logic [ALEN-1:0] araddr_q, araddr_d;
  logic            rf_wvalid_q, rf_wvalid_d;
  logic [4:0]      rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0] rf_wdata_q, rf_wdata_d;
  logic            exc_valid_q, exc_valid_d;
  logic [3:0]      exc_cause_q, exc_cause_d;
  logic [XLEN-1:0] exc_tval_q, exc_tval_d;

  logic [XLEN-1:0] ea, ext_data;
  logic            ill, mis, push, pop, r_hs, skip_pop, head_vld, out_free;
  lq_entry_t       head, new_ent;

  assign ea  = i_base_addr + i_offset;
  assign ill = width_illegal(i_width, XLEN);

`ifdef LOAD_MISALIGN_EXC_EN
  always_comb begin
    case (i_width[1:0])
      2'd0:    mis = 1'b0;
      2'd1:    mis = ea[0];
      2'd2:    mis = |ea[1:0];
      default: mis = |ea[2:0];
    endcase
  end
`else
  assign mis = 1'b0;
`endif

  always_comb begin
    new_ent.dest  = i_dest;
    new_ent.width = width_e'(i_width);
    new_ent.ea    = EA_W'(ea);
    new_ent.skip  = ill || mis;
    new_ent.cause = ill ? CAUSE_ILLEGAL : (mis ? CAUSE_MISALIGN : 4'd0);
  end

  // AR register can only take a new address once the previous one is gone.
  assign o_tready = (cnt_q < CW'(DEPTH)) && (!arvalid_q || i_arready);
  assign push     = i_tvalid && o_tready;
  assign head     = fifo_q[rd_ptr_q];
  assign head_vld = (cnt_q != '0);
  // A retirement needs a free write port and no exception pulse in flight.
  assign out_free = (!rf_wvalid_q || i_rf_wready) && !exc_valid_q;
  assign o_rready = head_vld && !head.skip && out_free;
  assign r_hs     = o_rready && i_rvalid;
  assign skip_pop = head_vld && head.skip && out_free;
  assign pop      = r_hs || skip_pop;

  load_extract #(.XLEN(XLEN), .DLEN(DLEN), .OFFW(OFFW)) u_extract (
    .rdata  (i_rdata),
    .offset (head.ea[OFFW-1:0]),
    .width  (head.width),
    .data   (ext_data)
  );

  always_comb begin
    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = new_ent;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) rd_ptr_d = rd_ptr_q + PW'(1);
    cnt_d = cnt_q + CW'(push) - CW'(pop);

    arvalid_d = arvalid_q && !i_arready;
    araddr_d  = araddr_q;
    if (push && !new_ent.skip) begin
      arvalid_d = 1'b1;
      araddr_d  = ALEN'(ea) & ~ALEN'(SLEN - 1);
    end

    rf_wvalid_d = rf_wvalid_q && !i_rf_wready;
    rf_waddr_d  = rf_waddr_q;
    rf_wdata_d  = rf_wdata_q;
    exc_valid_d = 1'b0;
    exc_cause_d = exc_cause_q;
    exc_tval_d  = exc_tval_q;
    if (r_hs) begin
      if (i_rresp != 2'b00) begin
        exc_valid_d = 1'b1;
        exc_cause_d = CAUSE_ACCESS;
        exc_tval_d  = head.ea[XLEN-1:0];
      end else if (head.dest != 5'd0) begin
        rf_wvalid_d = 1'b1;
        rf_waddr_d  = head.dest;
        rf_wdata_d  = ext_data;
      end
    end else if (skip_pop) begin
      exc_valid_d = 1'b1;
      exc_cause_d = head.cause;
      exc_tval_d  = head.ea[XLEN-1:0];
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      for (int i = 0; i < DEPTH; i++) fifo_q[i] <= '0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      cnt_q       <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      rf_wvalid_q <= 1'b0;
      rf_waddr_q  <= '0;
      rf_wdata_q  <= '0;
      exc_valid_q <= 1'b0;
      exc_cause_q <= '0;
      exc_tval_q  <= '0;
    end else begin
      fifo_q      <= fifo_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      cnt_q       <= cnt_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      rf_wvalid_q <= rf_wvalid_d;
      rf_waddr_q  <= rf_waddr_d;
      rf_wdata_q  <= rf_wdata_d;
      exc_valid_q <= exc_valid_d;
      exc_cause_q <= exc_cause_d;
      exc_tval_q  <= exc_tval_d;
    end
  end

  assign o_arvalid   = arvalid_q;
  assign o_araddr    = araddr_q;
  assign o_arprot    = 3'b000;
  assign o_rf_wvalid = rf_wvalid_q;
  assign o_rf_waddr  = rf_waddr_q;
  assign o_rf_wdata  = rf_wdata_q;
  assign o_exc_valid = exc_valid_q;
  assign o_exc_cause = exc_cause_q;
  assign o_exc_tval  = exc_tval_q;
  assign o_busy      = head_vld || rf_wvalid_q || exc_valid_q;

endmodule

// File: tb/tb_load_queue_unit.sv
// Bench for load_queue_unit: directed test-plan steps plus randomized loads, checked
// against a transaction-level model (expected AR order and in-order retirement list).
module tb_load_queue_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        i_tvalid, o_tready;
  logic [63:0] i_base_addr, i_offset;
  logic [2:0]  i_width;
  logic [4:0]  i_dest;
  logic [63:0] o_araddr;
  logic [2:0]  o_arprot;
  logic        o_arvalid, i_arready;
  logic [63:0] i_rdata;
  logic [1:0]  i_rresp;
  logic        i_rvalid, o_rready;
  logic        o_rf_wvalid, i_rf_wready;
  logic [4:0]  o_rf_waddr;
  logic [63:0] o_rf_wdata;
  logic        o_exc_valid;
  logic [3:0]  o_exc_cause;
  logic [63:0] o_exc_tval;
  logic        o_busy;

  always #5 clk = ~clk;

  load_queue_unit #(.XLEN(64), .DEPTH(4)) dut (
    .clk(clk), .rstn(rstn),
    .i_tvalid(i_tvalid), .o_tready(o_tready),
    .i_base_addr(i_base_addr), .i_offset(i_offset), .i_width(i_width), .i_dest(i_dest),
    .o_araddr(o_araddr), .o_arprot(o_arprot), .o_arvalid(o_arvalid), .i_arready(i_arready),
    .i_rdata(i_rdata), .i_rresp(i_rresp), .i_rvalid(i_rvalid), .o_rready(o_rready),
    .o_rf_wvalid(o_rf_wvalid), .i_rf_wready(i_rf_wready), .o_rf_waddr(o_rf_waddr),
    .o_rf_wdata(o_rf_wdata), .o_exc_valid(o_exc_valid), .o_exc_cause(o_exc_cause),
    .o_exc_tval(o_exc_tval), .o_busy(o_busy)
  );

  typedef struct { logic [63:0] base; logic [63:0] off; logic [2:0] width; logic [4:0] dest; } req_t;
  typedef struct { bit is_exc; logic [4:0] dest; logic [63:0] data; logic [3:0] cause; logic [63:0] tval; } ret_t;
  typedef struct { logic [63:0] addr; bit outp; } ar_t;
  typedef struct { logic [63:0] addr; int t; bit outp; } beat_t;

  req_t  req_q[$];
  ret_t  exp_q[$];
  ar_t   exp_ar[$];
  beat_t beats[$];
  logic [63:0] mem_ov[logic [63:0]];

  int ntests = 0, nfail = 0, cyc = 0, ar_cnt = 0, exc_cnt = 0, rdelay = 0;
  bit ar_rand = 0, wr_rand = 0, wr_low = 0, lat_pend = 0;
  logic [63:0] last_wdata = '0, last_tval = '0, last_araddr = '0;
  logic [3:0]  last_cause = '0;
  logic        last_tready = 1'b0;

  // Memory image: directed overrides, otherwise an address hash.
  function automatic logic [63:0] memval(input logic [63:0] a);
    if (mem_ov.exists(a)) return mem_ov[a];
    return {a[31:0] ^ 32'h5A5A_C3C3, a[31:0] * 32'h9E37_79B1};
  endfunction

  // Slave answers SLVERR for any address in a 0x?E??? window.
  function automatic bit bad(input logic [63:0] a);
    return a[15:12] == 4'hE;
  endfunction

  function automatic logic [63:0] load_val(input logic [63:0] ea, input logic [2:0] w);
    int n;
    logic [63:0] v, mask;
    n    = 1 << w[1:0];
    v    = memval({ea[63:3], 3'b000}) >> (8 * int'(ea[2:0]));
    mask = (n == 8) ? '1 : ((64'd1 << (8 * n)) - 64'd1);
    v    = v & mask;
    if (!w[2] && n < 8 && v[8*n-1]) v = v | ~mask;
    return v;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [63:0] base, input logic [63:0] off,
                      input logic [2:0] w, input logic [4:0] d);
    req_t r;
    r.base = base; r.off = off; r.width = w; r.dest = d;
    req_q.push_back(r);
  endtask

  task automatic model_push(input req_t r);
    logic [63:0] ea;
    bit ill, mis;
    ret_t e;
    ar_t a;
    ea  = r.base + r.off;
    ill = (r.width == 3'b111);
    mis = 0;
`ifdef LOAD_MISALIGN_EXC_EN
    mis = (ea % (64'd1 << r.width[1:0])) != 64'd0;
`endif
    e.is_exc = 1; e.dest = r.dest; e.data = '0; e.tval = ea;
    e.cause  = ill ? 4'd2 : (mis ? 4'd4 : 4'd5);
    if (ill || mis) begin
      exp_q.push_back(e);
      return;
    end
    a.addr = {ea[63:3], 3'b000};
    a.outp = bad(ea) || (r.dest != 5'd0);
    exp_ar.push_back(a);
    if (bad(ea)) exp_q.push_back(e);
    else if (r.dest != 5'd0) begin
      e.is_exc = 0; e.cause = '0; e.tval = '0; e.data = load_val(ea, r.width);
      exp_q.push_back(e);
    end
  endtask

  // One clock: drive at the falling edge, observe 1ns later, handshakes land on the next rise.
  task automatic cycle();
    ar_t a;
    beat_t b;
    ret_t e;
    @(negedge clk);
    cyc++;
    if (req_q.size() > 0) begin
      i_tvalid = 1; i_base_addr = req_q[0].base; i_offset = req_q[0].off;
      i_width = req_q[0].width; i_dest = req_q[0].dest;
    end else i_tvalid = 0;
    i_arready   = ar_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    i_rf_wready = wr_low ? 1'b0 : (wr_rand ? 1'($urandom_range(0, 1)) : 1'b1);
    if (beats.size() > 0 && cyc >= beats[0].t) begin
      i_rvalid = 1; i_rdata = memval(beats[0].addr);
      i_rresp = bad(beats[0].addr) ? 2'b10 : 2'b00;
    end else begin
      i_rvalid = 0; i_rdata = '0; i_rresp = 2'b00;
    end
    #1;
    last_tready = o_tready;
    if (lat_pend) chk("result_latency", 64'(o_rf_wvalid | o_exc_valid), 64'd1);
    lat_pend = 0;
    if (i_tvalid && o_tready) model_push(req_q.pop_front());
    if (o_arvalid && i_arready) begin
      ar_cnt++;
      last_araddr = o_araddr;
      if (exp_ar.size() == 0) chk("ar_spurious", 64'(exp_ar.size()), 64'd1);
      else begin
        a = exp_ar.pop_front();
        chk("ar_addr", o_araddr, a.addr);
        b.addr = a.addr; b.t = cyc + 1 + rdelay; b.outp = a.outp;
        beats.push_back(b);
      end
    end
    if (i_rvalid && o_rready) begin
      b = beats.pop_front();
      lat_pend = b.outp;
    end
    if (o_rf_wvalid && i_rf_wready) begin
      if (exp_q.size() == 0) chk("rf_spurious", 64'(exp_q.size()), 64'd1);
      else begin
        e = exp_q.pop_front();
        chk("rf_kind", 64'(e.is_exc), 64'd0);
        chk("rf_waddr", 64'(o_rf_waddr), 64'(e.dest));
        chk("rf_wdata", o_rf_wdata, e.data);
        last_wdata = o_rf_wdata;
      end
    end
    if (o_exc_valid) begin
      exc_cnt++;
      last_cause = o_exc_cause;
      last_tval  = o_exc_tval;
      if (exp_q.size() == 0) chk("exc_spurious", 64'(exp_q.size()), 64'd1);
      else begin
        e = exp_q.pop_front();
        chk("exc_kind", 64'(e.is_exc), 64'd1);
        chk("exc_cause", 64'(o_exc_cause), 64'(e.cause));
        chk("exc_tval", o_exc_tval, e.tval);
      end
    end
  endtask

  task automatic drain(input int maxc);
    int n;
    n = 0;
    while ((req_q.size() > 0 || exp_q.size() > 0 || beats.size() > 0 || o_busy) && n < maxc) begin
      cycle();
      n++;
    end
    chk("drain_in_time", 64'(n < maxc), 64'd1);
    chk("idle_busy", 64'(o_busy), 64'd0);
  endtask

  initial begin
    int a0, e0;
    logic [11:0] oo;
    i_tvalid = 0; i_base_addr = '0; i_offset = '0; i_width = '0; i_dest = '0;
    i_arready = 0; i_rdata = '0; i_rresp = '0; i_rvalid = 0; i_rf_wready = 0;

    // reset state
    repeat (3) @(negedge clk);
    #1;
    chk("rst_arvalid", 64'(o_arvalid), 64'd0);
    chk("rst_rf_wvalid", 64'(o_rf_wvalid), 64'd0);
    chk("rst_exc_valid", 64'(o_exc_valid), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_rready", 64'(o_rready), 64'd0);
    chk("rst_araddr", o_araddr, 64'd0);
    chk("rst_waddr", 64'(o_rf_waddr), 64'd0);
    chk("rst_wdata", o_rf_wdata, 64'd0);
    chk("rst_cause", 64'(o_exc_cause), 64'd0);
    chk("rst_tval", o_exc_tval, 64'd0);
    chk("rst_arprot", 64'(o_arprot), 64'd0);
    rstn = 1;

    // LB / LBU of a 0x80 byte at lane 3
    mem_ov[64'h1000] = 64'h0000_0000_8000_0000;
    send(64'h1000, 64'd3, 3'b000, 5'd5);
    drain(100);
    chk("lb_araddr", last_araddr, 64'h1000);
    chk("lb_wdata", last_wdata, 64'hFFFF_FFFF_FFFF_FF80);
    send(64'h1000, 64'd3, 3'b100, 5'd6);
    drain(100);
    chk("lbu_wdata", last_wdata, 64'h80);

    // four LDs fill the queue; the fifth is refused
    rdelay = 10;
    a0 = ar_cnt;
    for (int i = 0; i < 5; i++) send(64'h2000 + 64'(8 * i), 64'd0, 3'b011, 5'(10 + i));
    repeat (5) cycle();
    chk("full_tready", 64'(last_tready), 64'd0);
    chk("full_ar_cnt", 64'(ar_cnt - a0), 64'd4);
    drain(300);
    rdelay = 0;

    // access fault on the middle of three loads
    e0 = exc_cnt;
    send(64'h3000, 64'd0, 3'b010, 5'd1);
    send(64'hE000, 64'd8, 3'b011, 5'd2);
    send(64'h3010, 64'd0, 3'b001, 5'd3);
    drain(200);
    chk("err_cnt", 64'(exc_cnt - e0), 64'd1);
    chk("err_cause", 64'(last_cause), 64'd5);
    chk("err_tval", last_tval, 64'hE008);

    // illegal width between two loads
    a0 = ar_cnt;
    send(64'h4000, 64'd0, 3'b011, 5'd4);
    send(64'h4100, 64'd0, 3'b111, 5'd6);
    send(64'h4008, 64'd0, 3'b011, 5'd7);
    drain(200);
    chk("ill_ar_cnt", 64'(ar_cnt - a0), 64'd2);
    chk("ill_cause", 64'(last_cause), 64'd2);
    chk("ill_tval", last_tval, 64'h4100);

    // misaligned LW
    mem_ov[64'h1000] = 64'h1122_3344_5566_7788;
    a0 = ar_cnt;
    send(64'h1000, 64'd2, 3'b010, 5'd8);
    send(64'h1000, 64'd6, 3'b010, 5'd9);
    drain(200);
`ifdef LOAD_MISALIGN_EXC_EN
    chk("mis_ar_cnt", 64'(ar_cnt - a0), 64'd0);
    chk("mis_cause", 64'(last_cause), 64'd4);
    chk("mis_tval", last_tval, 64'h1006);
`else
    chk("mis_ar_cnt", 64'(ar_cnt - a0), 64'd2);
    chk("mis_araddr", last_araddr, 64'h1000);
    chk("mis_wdata", last_wdata, 64'h1122);
`endif

    // write port back-pressure with two beats pending
    wr_low = 1;
    send(64'h5000, 64'd0, 3'b011, 5'd11);
    send(64'h5008, 64'd0, 3'b011, 5'd12);
    repeat (6) cycle();
    for (int i = 0; i < 5; i++) begin
      cycle();
      chk("bp_rready", 64'(o_rready), 64'd0);
      chk("bp_wvalid", 64'(o_rf_wvalid), 64'd1);
      chk("bp_wdata", o_rf_wdata, (exp_q.size() > 0) ? exp_q[0].data : 64'hDEAD);
    end
    wr_low = 0;
    drain(100);

    // reset in the middle of traffic drops everything
    send(64'h6000, 64'd0, 3'b011, 5'd13);
    send(64'h6008, 64'd0, 3'b011, 5'd14);
    repeat (3) cycle();
    @(negedge clk);
    rstn = 0;
    #1;
    chk("mid_rst_busy", 64'(o_busy), 64'd0);
    chk("mid_rst_arvalid", 64'(o_arvalid), 64'd0);
    req_q.delete(); exp_q.delete(); exp_ar.delete(); beats.delete();
    lat_pend = 0;
    @(negedge clk);
    rstn = 1;

    // randomized traffic
    ar_rand = 1; wr_rand = 1;
    for (int b = 0; b < 6; b++) begin
      rdelay = $urandom_range(0, 3);
      for (int i = 0; i < 50; i++) begin
        oo = 12'($urandom);
        send({$urandom, $urandom}, {{52{oo[11]}}, oo}, 3'($urandom_range(0, 7)),
             5'($urandom_range(0, 31)));
      end
      drain(3000);
    end

    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
